// File: rtl/inst_prefetch_unit.sv
// inst_prefetch_unit
//   Instruction prefetcher between a multi-cycle instruction memory and decode.
//   Issues one word fetch at a time over a req/ack handshake, buffers returned
//   words with their PCs in a DEPTH-entry FIFO, and presents the FIFO head to
//   decode over valid/ready. A redirect from execute flushes the FIFO and
//   restarts fetch at the (word-aligned) target PC.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_req        fetch request, held until imem_ack
//   imem_addr       word-aligned fetch address, stable while imem_req=1
//   imem_ack        memory accepted request; imem_rdata valid this cycle
//   imem_rdata      returned instruction word
//   redirect_valid  taken branch/jump this cycle
//   redirect_pc     new fetch target (low two bits ignored)
//   inst_valid      FIFO head valid
//   inst, inst_pc   FIFO head instruction and its PC
//   inst_ready      decode consumes head when inst_valid & inst_ready

module inst_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        disc_addr_q, disc_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        inst_pc_q, inst_pc_d;
    logic [31:0]        mem_inst_q [DEPTH];
    logic [31:0]        mem_pc_q   [DEPTH];

    logic               push;
    logic               pop;
    logic               credit_ok;
    logic [31:0]        redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'd3;

    // A redirect cancels any push or pop in the same cycle.
    assign push = (state_q == S_REQ) && imem_ack && !redirect_valid;
    assign pop  = (count_q != '0) && inst_ready && !redirect_valid;

    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

    // ------------------------------------------------------------------
    // FIFO bookkeeping and head register
    // ------------------------------------------------------------------
    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);

            // The head register mirrors mem[rd_ptr] but is only reloaded when
            // the head changes, so it holds its last value once the FIFO empties.
            if (pop && (count_q > CNT_W'(1))) begin
                inst_d    = mem_inst_q[rd_ptr_nxt];
                inst_pc_d = mem_pc_q[rd_ptr_nxt];
            end else if (push && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
                inst_d    = imem_rdata;
                inst_pc_d = fetch_pc_q;
            end
        end
    end

    // Credit is judged on next-cycle occupancy so at most DEPTH entries exist
    // even counting the single outstanding request.
    assign credit_ok = (count_d < CNT_W'(DEPTH));

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            unique case (state_q)
                S_IDLE: begin
                    state_d = credit_ok ? S_REQ : S_IDLE;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        state_d = credit_ok ? S_REQ : S_IDLE;
                    end else begin
                        // Keep presenting the old address until the memory acks.
                        state_d     = S_DISCARD;
                        disc_addr_d = fetch_pc_q;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        state_d = credit_ok ? S_REQ : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (credit_ok) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = credit_ok ? S_REQ : S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        state_d = credit_ok ? S_REQ : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req   = (state_q != S_IDLE);
    assign imem_addr  = (state_q == S_DISCARD) ? disc_addr_q : fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench for inst_prefetch_unit: per-cycle vector table covering
// streaming, back-pressure, redirects, PC wrap and mid-request reset, plus a
// hand-written sequence with a slow (ack every 3rd cycle) memory.

module tb_inst_prefetch_unit;

    localparam logic [31:0] K = 32'hDEAD_0000;  // imem_rdata = addr ^ K

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ K;

    inst_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    function automatic vec_t v(logic r, logic a, logic rd, logic rv, logic [31:0] rpc,
                               logic rq, logic [31:0] ad, logic vl, logic [31:0] pc);
        vec_t t;
        t.rst = r;  t.ack = a;   t.rdy = rd;  t.rv = rv;  t.rpc = rpc;
        t.req = rq; t.addr = ad; t.valid = vl; t.pc = pc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int          ndeliv;
        logic [31:0] exp_pc;
        logic [31:0] exp_req_addr;
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;

        //        rst ack rdy rv rpc            req addr          vld pc
        vecs[0]  = v(1, 1, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0);
        vecs[1]  = v(0, 1, 1, 0, 32'h0,          1, 32'h0,         0, 32'h0);
        vecs[2]  = v(0, 1, 1, 0, 32'h0,          1, 32'h4,         1, 32'h0);
        vecs[3]  = v(0, 1, 1, 0, 32'h0,          1, 32'h8,         1, 32'h4);
        vecs[4]  = v(0, 1, 1, 0, 32'h0,          1, 32'hC,         1, 32'h8);
        // decode stalls: fill to DEPTH, then request drops
        vecs[5]  = v(0, 1, 0, 0, 32'h0,          1, 32'h10,        1, 32'h8);
        vecs[6]  = v(0, 1, 0, 0, 32'h0,          1, 32'h14,        1, 32'h8);
        vecs[7]  = v(0, 1, 0, 0, 32'h0,          0, 32'h18,        1, 32'h8);
        vecs[8]  = v(0, 1, 0, 0, 32'h0,          0, 32'h18,        1, 32'h8);
        vecs[9]  = v(0, 1, 0, 0, 32'h0,          0, 32'h18,        1, 32'h8);
        // drain in order while fetch resumes
        vecs[10] = v(0, 1, 1, 0, 32'h0,          1, 32'h18,        1, 32'hC);
        vecs[11] = v(0, 1, 1, 0, 32'h0,          1, 32'h1C,        1, 32'h10);
        vecs[12] = v(0, 1, 1, 0, 32'h0,          1, 32'h20,        1, 32'h14);
        vecs[13] = v(0, 1, 1, 0, 32'h0,          1, 32'h24,        1, 32'h18);
        vecs[14] = v(0, 1, 1, 0, 32'h0,          1, 32'h28,        1, 32'h1C);
        vecs[15] = v(0, 1, 1, 0, 32'h0,          1, 32'h2C,        1, 32'h20);
        // redirect with ack and pop in the same cycle
        vecs[16] = v(0, 1, 1, 1, 32'h200,        1, 32'h200,       0, 32'h0);
        vecs[17] = v(0, 1, 1, 0, 32'h0,          1, 32'h204,       1, 32'h200);
        // redirect to 0x103 while a request waits for ack
        vecs[18] = v(0, 0, 1, 0, 32'h0,          1, 32'h204,       0, 32'h0);
        vecs[19] = v(0, 0, 1, 1, 32'h103,        1, 32'h204,       0, 32'h0);
        vecs[20] = v(0, 0, 1, 0, 32'h0,          1, 32'h204,       0, 32'h0);
        vecs[21] = v(0, 1, 1, 0, 32'h0,          1, 32'h100,       0, 32'h0);
        vecs[22] = v(0, 1, 1, 0, 32'h0,          1, 32'h104,       1, 32'h100);
        // redirect into DISCARD, then a second redirect while discarding
        vecs[23] = v(0, 0, 0, 0, 32'h0,          1, 32'h104,       1, 32'h100);
        vecs[24] = v(0, 0, 1, 1, 32'h300,        1, 32'h104,       0, 32'h0);
        vecs[25] = v(0, 0, 1, 1, 32'h404,        1, 32'h104,       0, 32'h0);
        vecs[26] = v(0, 1, 1, 0, 32'h0,          1, 32'h404,       0, 32'h0);
        vecs[27] = v(0, 1, 1, 0, 32'h0,          1, 32'h408,       1, 32'h404);
        // fetch_pc wrap past 0xFFFFFFFC
        vecs[28] = v(0, 1, 1, 1, 32'hFFFF_FFFF,  1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[29] = v(0, 1, 1, 0, 32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC);
        vecs[30] = v(0, 1, 1, 0, 32'h0,          1, 32'h4,         1, 32'h0);
        // reset while a request is outstanding
        vecs[31] = v(0, 0, 1, 0, 32'h0,          1, 32'h4,         0, 32'h0);
        vecs[32] = v(1, 0, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0);
        vecs[33] = v(0, 1, 1, 0, 32'h0,          1, 32'h0,         0, 32'h0);
        vecs[34] = v(0, 1, 1, 0, 32'h0,          1, 32'h4,         1, 32'h0);

        rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        for (int i = 0; i < NV; i++) begin
            rst            = vecs[i].rst;
            imem_ack       = vecs[i].ack;
            inst_ready     = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].req});
            chk($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].valid});
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_pc", i),   inst_pc, vecs[i].pc);
                chk($sformatf("v%0d_inst", i), inst,    vecs[i].pc ^ K);
            end
        end

        // Reset from a state where the head register holds a nonzero word.
        rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_req",     {31'd0, imem_req},   32'd0);
        chk("rst_addr",    imem_addr,           32'h0);
        chk("rst_valid",   {31'd0, inst_valid}, 32'd0);
        chk("rst_inst",    inst,                32'h0);
        chk("rst_inst_pc", inst_pc,             32'h0);

        // Slow memory: ack every 3rd cycle, decode always ready.
        rst = 1'b0;
        ndeliv = 0; exp_pc = 32'h0; exp_req_addr = 32'h0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        imem_ack = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk);
            #1;
            if (prev_req && !prev_ack)
                chk($sformatf("slow%0d_addr_stable", cyc), imem_addr, prev_addr);
            if (inst_valid) begin
                chk($sformatf("slow%0d_pc", cyc),   inst_pc, exp_pc);
                chk($sformatf("slow%0d_inst", cyc), inst,    exp_pc ^ K);
                exp_pc = exp_pc + 32'd4;
                ndeliv++;
            end
            imem_ack = ((cyc % 3) == 2);
            if (imem_ack && imem_req) begin
                chk($sformatf("slow%0d_ack_addr", cyc), imem_addr, exp_req_addr);
                exp_req_addr = exp_req_addr + 32'd4;
            end
            prev_req  = imem_req;
            prev_addr = imem_addr;
            prev_ack  = imem_ack;
        end
        checks++;
        if (ndeliv < 15) begin
            errors++;
            $display("FAIL slow_deliveries: got %0d required at least 15", ndeliv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
